// File: rtl/falc_pbus_pkg.sv
// falc_pbus_pkg: state encodings, timer widths and default timing for the framer bus bridge
package falc_pbus_pkg;

    localparam int DEF_NUM_CS   = 2;
    localparam int DEF_ALE_CYC  = 3;
    localparam int DEF_STRB_CYC = 3;
    localparam int DEF_REC_CYC  = 2;
    localparam int DEF_GNT_TMO  = 255;

    // ALE/strobe/recovery timers reach 15, the grant timeout reaches 65535
    localparam int CNT_W = 4;
    localparam int TMO_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_ALE,
        ST_STRB,
        ST_REC,
        ST_DONE
    } state_e;

    // Writes wrap the WRn pulse with one setup and one hold clock of driven data
    typedef enum logic [1:0] {
        PH_SETUP,
        PH_ACT,
        PH_HOLD
    } strb_ph_e;

endpackage

// File: rtl/falc_int_sync.sv
// falc_int_sync: per-bit two-flop synchroniser for framer interrupt lines
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, clears both stages
//   d_i    : asynchronous inputs
//   q_o    : synchronised outputs, two clocks behind d_i
module falc_int_sync #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/falc_pbus_bridge.sv
// falc_pbus_bridge: Wishbone-style slave to muxed 8-bit framer parallel bus bridge
//   PHY_CLK33_I / PHY_RSTn_I           : clock, asynchronous active-low reset
//   WB_ADD_I/WB_DATA_I/WB_STB_I/WB_WE_I: request; [9:2] register, [11:10] chip, data[7:0]
//   WB_DATA_O/WB_ACK_O/WB_VALID_O/WB_ERR_O : read data, write done, read valid, error
//   F56_WB_REQ_O / F56_WB_GNT_I        : shared-bus request and grant
//   F56_BADD_*, F56_ALE_O, F56_RDn_O, F56_WRn_O, F56_CSn_O : framer muxed bus
//   F56_INT_I / F56_INT_O              : raw and synchronised framer interrupts
module falc_pbus_bridge
    import falc_pbus_pkg::*;
#(
    parameter int NUM_CS   = DEF_NUM_CS,
    parameter int ALE_CYC  = DEF_ALE_CYC,
    parameter int STRB_CYC = DEF_STRB_CYC,
    parameter int REC_CYC  = DEF_REC_CYC,
    parameter int GNT_TMO  = DEF_GNT_TMO
) (
    input  logic              PHY_CLK33_I,
    input  logic              PHY_RSTn_I,
    input  logic [31:0]       WB_ADD_I,
    input  logic [31:0]       WB_DATA_I,
    output logic [31:0]       WB_DATA_O,
    input  logic              WB_STB_I,
    input  logic              WB_WE_I,
    output logic              WB_ACK_O,
    output logic              WB_VALID_O,
    output logic              WB_ERR_O,
    output logic              F56_WB_REQ_O,
    input  logic              F56_WB_GNT_I,
    input  logic [7:0]        F56_BADD_I,
    output logic [7:0]        F56_BADD_O,
    output logic              F56_BADD_DIR_O,
    output logic              F56_ALE_O,
    output logic              F56_RDn_O,
    output logic              F56_WRn_O,
    output logic [NUM_CS-1:0] F56_CSn_O,
    input  logic [NUM_CS-1:0] F56_INT_I,
    output logic [NUM_CS-1:0] F56_INT_O
);

    state_e             state_q;
    strb_ph_e           ph_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [TMO_W-1:0]   tmo_q;
    logic [7:0]         addr_q;
    logic [1:0]         chip_q;
    logic               we_q;
    logic [7:0]         wdata_q;
    logic [7:0]         rdata_q;
    logic [7:0]         dout_q;
    logic               ack_q;
    logic               valid_q;
    logic               err_q;
    logic               req_q;
    logic [7:0]         badd_q;
    logic               dir_q;
    logic               ale_q;
    logic               rdn_q;
    logic               wrn_q;
    logic [NUM_CS-1:0]  csn_q;
    logic               unused_bits;

    assign unused_bits = ^{WB_ADD_I[31:12], WB_ADD_I[1:0], WB_DATA_I[31:8]};

    always_ff @(posedge PHY_CLK33_I or negedge PHY_RSTn_I) begin
        if (!PHY_RSTn_I) begin
            state_q <= ST_IDLE;
            ph_q    <= PH_SETUP;
            cnt_q   <= '0;
            tmo_q   <= '0;
            addr_q  <= '0;
            chip_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            dout_q  <= '0;
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            badd_q  <= '0;
            dir_q   <= 1'b0;
            ale_q   <= 1'b0;
            rdn_q   <= 1'b1;
            wrn_q   <= 1'b1;
            csn_q   <= '1;
        end else if (!WB_STB_I) begin
            // Master withdrew: park the bus immediately, never finish a strobe
            state_q <= ST_IDLE;
            dout_q  <= '0;
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            badd_q  <= '0;
            dir_q   <= 1'b0;
            ale_q   <= 1'b0;
            rdn_q   <= 1'b1;
            wrn_q   <= 1'b1;
            csn_q   <= '1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    addr_q  <= WB_ADD_I[9:2];
                    chip_q  <= WB_ADD_I[11:10];
                    we_q    <= WB_WE_I;
                    wdata_q <= WB_DATA_I[7:0];
                    tmo_q   <= '0;
                    if (int'(WB_ADD_I[11:10]) >= NUM_CS) begin
                        err_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        req_q   <= 1'b1;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (F56_WB_GNT_I) begin
                        badd_q  <= addr_q;
                        dir_q   <= 1'b1;
                        ale_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_ALE;
                    end else if (tmo_q == TMO_W'(GNT_TMO - 1)) begin
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                ST_ALE: begin
                    if (cnt_q == CNT_W'(ALE_CYC - 1)) begin
                        ale_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_STRB;
                        if (we_q) begin
                            badd_q <= wdata_q;
                            ph_q   <= PH_SETUP;
                        end else begin
                            badd_q <= '0;
                            dir_q  <= 1'b0;
                            csn_q  <= ~(NUM_CS'(1) << chip_q);
                            rdn_q  <= 1'b0;
                            ph_q   <= PH_ACT;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_STRB: begin
                    case (ph_q)
                        PH_SETUP: begin
                            csn_q <= ~(NUM_CS'(1) << chip_q);
                            wrn_q <= 1'b0;
                            cnt_q <= '0;
                            ph_q  <= PH_ACT;
                        end
                        PH_ACT: begin
                            if (cnt_q == CNT_W'(STRB_CYC - 1)) begin
                                csn_q <= '1;
                                rdn_q <= 1'b1;
                                wrn_q <= 1'b1;
                                cnt_q <= '0;
                                if (we_q) begin
                                    ph_q <= PH_HOLD;
                                end else begin
                                    rdata_q <= F56_BADD_I;
                                    if (REC_CYC == 0) begin
                                        req_q   <= 1'b0;
                                        valid_q <= 1'b1;
                                        dout_q  <= F56_BADD_I;
                                        state_q <= ST_DONE;
                                    end else begin
                                        state_q <= ST_REC;
                                    end
                                end
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                        PH_HOLD: begin
                            badd_q <= '0;
                            dir_q  <= 1'b0;
                            if (REC_CYC == 0) begin
                                req_q   <= 1'b0;
                                ack_q   <= 1'b1;
                                state_q <= ST_DONE;
                            end else begin
                                state_q <= ST_REC;
                            end
                        end
                        default: ph_q <= PH_SETUP;
                    endcase
                end
                ST_REC: begin
                    if (cnt_q == CNT_W'(REC_CYC - 1)) begin
                        req_q   <= 1'b0;
                        ack_q   <= we_q;
                        valid_q <= !we_q;
                        dout_q  <= we_q ? 8'h00 : rdata_q;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: state_q <= ST_DONE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    falc_int_sync #(.W(NUM_CS)) u_int_sync (
        .clk_i  (PHY_CLK33_I),
        .rst_ni (PHY_RSTn_I),
        .d_i    (F56_INT_I),
        .q_o    (F56_INT_O)
    );

    assign WB_DATA_O      = {24'h0, dout_q};
    assign WB_ACK_O       = ack_q;
    assign WB_VALID_O     = valid_q;
    assign WB_ERR_O       = err_q;
    assign F56_WB_REQ_O   = req_q;
    assign F56_BADD_O     = badd_q;
    assign F56_BADD_DIR_O = dir_q;
    assign F56_ALE_O      = ale_q;
    assign F56_RDn_O      = rdn_q;
    assign F56_WRn_O      = wrn_q;
    assign F56_CSn_O      = csn_q;

endmodule

// File: tb/tb_falc_pbus_bridge.sv
// tb_falc_pbus_bridge: directed self-checking bench for the framer bus bridge
module tb_falc_pbus_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] add, wdat, rdat;
    logic        stb, we, ack, valid, err, req, gnt, dir, ale, rdn, wrn;
    logic [7:0]  badd_i, badd_o;
    logic [1:0]  csn, int_i, int_o;
    int          checks = 0;
    int          failures = 0;

    localparam logic [17:0] IDLE_V = {6'b0, 2'b11, 2'b11, 8'h00};

    always #5 clk = ~clk;

    falc_pbus_bridge #(
        .NUM_CS(2), .ALE_CYC(3), .STRB_CYC(3), .REC_CYC(2), .GNT_TMO(8)
    ) dut (
        .PHY_CLK33_I    (clk),
        .PHY_RSTn_I     (rst_n),
        .WB_ADD_I       (add),
        .WB_DATA_I      (wdat),
        .WB_DATA_O      (rdat),
        .WB_STB_I       (stb),
        .WB_WE_I        (we),
        .WB_ACK_O       (ack),
        .WB_VALID_O     (valid),
        .WB_ERR_O       (err),
        .F56_WB_REQ_O   (req),
        .F56_WB_GNT_I   (gnt),
        .F56_BADD_I     (badd_i),
        .F56_BADD_O     (badd_o),
        .F56_BADD_DIR_O (dir),
        .F56_ALE_O      (ale),
        .F56_RDn_O      (rdn),
        .F56_WRn_O      (wrn),
        .F56_CSn_O      (csn),
        .F56_INT_I      (int_i),
        .F56_INT_O      (int_o)
    );

    function automatic logic [17:0] bus_v();
        return {ack, valid, err, req, dir, ale, rdn, wrn, csn, badd_o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic w, input logic [1:0] chip, input logic [7:0] a, input logic [7:0] d);
        add  = {20'hFFFFF, chip, a, 2'b11};
        wdat = {24'hABCDEF, d};
        we   = w;
        stb  = 1'b1;
    endtask

    task automatic test_reset();
        stb = 0; we = 0; add = 0; wdat = 0; gnt = 0; badd_i = 0; int_i = 0; rst_n = 0;
        #23;
        checks++;
        if (bus_v() !== IDLE_V) begin failures++; $display("FAIL reset_bus got=%h exp=%h", bus_v(), IDLE_V); end
        checks++;
        if (rdat !== 32'h0 || int_o !== 2'b00) begin failures++; $display("FAIL reset_data got=%h/%b exp=0/00", rdat, int_o); end
        rst_n = 1;
        tick(); tick();
        checks++;
        if (bus_v() !== IDLE_V) begin failures++; $display("FAIL idle_after_reset got=%h exp=%h", bus_v(), IDLE_V); end
    endtask

    task automatic test_read();
        int n_ale = 0, n_rd = 0, n_cs0 = 0, n_cs1 = 0, ale_bad = 0, viol = 0;
        logic got = 0;
        gnt = 1; badd_i = 8'h5A;
        start(1'b0, 2'd0, 8'h24, 8'h00);
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (ale) begin n_ale++; if (badd_o !== 8'h24 || dir !== 1'b1) ale_bad++; end
            if (!rdn) n_rd++;
            if (!csn[0]) n_cs0++;
            if (!csn[1]) n_cs1++;
            if (!wrn || (!rdn && dir) || (ale && csn !== 2'b11)) viol++;
            got = valid;
        end
        checks++;
        if (!got) begin failures++; $display("FAIL read_valid got=0 exp=1 (timeout)"); end
        checks++;
        if (n_ale !== 3 || ale_bad !== 0) begin failures++; $display("FAIL read_ale cycles=%0d bad=%0d exp=3/0", n_ale, ale_bad); end
        checks++;
        if (n_rd !== 3 || n_cs0 !== 3 || n_cs1 !== 0) begin failures++; $display("FAIL read_strobe rd=%0d cs0=%0d cs1=%0d exp=3/3/0", n_rd, n_cs0, n_cs1); end
        checks++;
        if (viol !== 0) begin failures++; $display("FAIL read_protocol viol=%0d exp=0", viol); end
        checks++;
        if (rdat !== 32'h0000005A || ack !== 1'b0 || err !== 1'b0 || req !== 1'b0) begin failures++; $display("FAIL read_data got=%h ack=%b err=%b req=%b exp=0000005a/0/0/0", rdat, ack, err, req); end
        tick();
        checks++;
        if (valid !== 1'b1 || rdat !== 32'h0000005A) begin failures++; $display("FAIL read_hold valid=%b data=%h exp=1/0000005a", valid, rdat); end
        stb = 0;
        tick();
        checks++;
        if (valid !== 1'b0 || rdat !== 32'h0) begin failures++; $display("FAIL read_release valid=%b data=%h exp=0/0", valid, rdat); end
    endtask

    task automatic test_write();
        int n_ale = 0, n_wr = 0, n_cs0 = 0, n_cs1 = 0, bad = 0, viol = 0, hold_n = 0, rec_n = 0;
        logic got = 0, seen_wr = 0, setup_ok = 0, p_wrn = 1, p_dir = 0;
        logic [7:0] p_badd = 0;
        gnt = 1;
        start(1'b1, 2'd1, 8'h10, 8'hC3);
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (ale) begin n_ale++; if (badd_o !== 8'h10 || dir !== 1'b1) bad++; end
            if (!wrn) begin
                n_wr++;
                if (badd_o !== 8'hC3 || dir !== 1'b1) bad++;
                if (p_wrn && p_badd === 8'hC3 && p_dir === 1'b1) setup_ok = 1;
                seen_wr = 1;
            end
            if (!csn[0]) n_cs0++;
            if (!csn[1]) n_cs1++;
            if (!rdn || (ale && csn !== 2'b11) || (!csn[1] && wrn)) viol++;
            got = ack;
            if (!got && seen_wr && wrn) begin
                if (dir) begin hold_n++; if (badd_o !== 8'hC3) bad++; end
                else rec_n++;
            end
            p_wrn = wrn; p_dir = dir; p_badd = badd_o;
        end
        checks++;
        if (!got) begin failures++; $display("FAIL write_ack got=0 exp=1 (timeout)"); end
        checks++;
        if (n_ale !== 3 || n_wr !== 3 || n_cs1 !== 3 || n_cs0 !== 0) begin failures++; $display("FAIL write_timing ale=%0d wr=%0d cs1=%0d cs0=%0d exp=3/3/3/0", n_ale, n_wr, n_cs1, n_cs0); end
        checks++;
        if (bad !== 0 || viol !== 0) begin failures++; $display("FAIL write_bus bad=%0d viol=%0d exp=0/0", bad, viol); end
        checks++;
        if (setup_ok !== 1'b1 || hold_n !== 1) begin failures++; $display("FAIL write_setup_hold setup=%b hold=%0d exp=1/1", setup_ok, hold_n); end
        checks++;
        if (rec_n !== 2) begin failures++; $display("FAIL write_recovery got=%0d exp=2", rec_n); end
        checks++;
        if (valid !== 1'b0 || rdat !== 32'h0 || req !== 1'b0) begin failures++; $display("FAIL write_done valid=%b data=%h req=%b exp=0/0/0", valid, rdat, req); end
        stb = 0;
        tick();
        checks++;
        if (bus_v() !== IDLE_V) begin failures++; $display("FAIL write_release got=%h exp=%h", bus_v(), IDLE_V); end
    endtask

    task automatic test_timeout();
        int n_req = 0, bad = 0;
        logic got = 0;
        gnt = 0;
        start(1'b0, 2'd0, 8'h33, 8'h00);
        for (int i = 0; i < 30 && !got; i++) begin
            tick();
            if (req) n_req++;
            if (csn !== 2'b11 || ale || !rdn || !wrn) bad++;
            got = err;
        end
        checks++;
        if (!got || n_req !== 8) begin failures++; $display("FAIL gnt_timeout err=%b req_cycles=%0d exp=1/8", got, n_req); end
        checks++;
        if (bad !== 0 || req !== 1'b0 || valid !== 1'b0) begin failures++; $display("FAIL gnt_timeout_bus bad=%0d req=%b valid=%b exp=0/0/0", bad, req, valid); end
        stb = 0;
        tick();
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL gnt_timeout_clear err=%b exp=0", err); end
        gnt = 1;
    endtask

    task automatic test_bad_chip();
        int bad = 0;
        gnt = 1;
        start(1'b0, 2'd3, 8'h01, 8'h00);
        tick();
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL bad_chip_err got=%b exp=1", err); end
        for (int i = 0; i < 6; i++) begin
            if (req || ale || dir || csn !== 2'b11 || !rdn || !wrn || valid || ack) bad++;
            tick();
        end
        checks++;
        if (bad !== 0 || err !== 1'b1) begin failures++; $display("FAIL bad_chip_bus activity=%0d err=%b exp=0/1", bad, err); end
        stb = 0;
        tick();
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL bad_chip_clear err=%b exp=0", err); end
    endtask

    task automatic test_abort();
        int bad = 0;
        logic hit = 0;
        gnt = 1;
        start(1'b1, 2'd0, 8'h44, 8'h99);
        for (int i = 0; i < 30 && !hit; i++) begin tick(); hit = !wrn; end
        checks++;
        if (!hit) begin failures++; $display("FAIL abort_reach_strobe got=0 exp=1 (timeout)"); end
        stb = 0;
        tick();
        checks++;
        if (bus_v() !== IDLE_V) begin failures++; $display("FAIL abort_idle got=%h exp=%h", bus_v(), IDLE_V); end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus_v() !== IDLE_V) bad++;
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL abort_quiet activity=%0d exp=0", bad); end
        start(1'b0, 2'd1, 8'h05, 8'h00);
        tick();
        checks++;
        if (req !== 1'b1) begin failures++; $display("FAIL abort_restart req=%b exp=1", req); end
        stb = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        logic hit = 0;
        gnt = 1; int_i = 2'b01;
        start(1'b1, 2'd1, 8'h20, 8'h55);
        for (int i = 0; i < 30 && !hit; i++) begin tick(); hit = !wrn; end
        checks++;
        if (!hit || int_o !== 2'b01) begin failures++; $display("FAIL rst_mid_setup strobe=%b int=%b exp=1/01", hit, int_o); end
        #2;
        rst_n = 0; stb = 0;
        #1;
        checks++;
        if (bus_v() !== IDLE_V || rdat !== 32'h0 || int_o !== 2'b00) begin failures++; $display("FAIL rst_mid_async got=%h data=%h int=%b exp=%h/0/00", bus_v(), rdat, int_o, IDLE_V); end
        int_i = 2'b00;
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus_v() !== IDLE_V) bad++;
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL rst_mid_quiet activity=%0d exp=0", bad); end
        int_i = 2'b10;
        tick();
        checks++;
        if (int_o !== 2'b00) begin failures++; $display("FAIL int_lat1 got=%b exp=00", int_o); end
        tick();
        checks++;
        if (int_o !== 2'b10) begin failures++; $display("FAIL int_lat2 got=%b exp=10", int_o); end
        int_i = 2'b00;
        tick();
        checks++;
        if (int_o !== 2'b10) begin failures++; $display("FAIL int_fall1 got=%b exp=10", int_o); end
        tick();
        checks++;
        if (int_o !== 2'b00) begin failures++; $display("FAIL int_fall2 got=%b exp=00", int_o); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_bad_chip();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
